rr_arb_mux: RTL

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/arb_mux_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_arb_mux.sv | 92 +++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating multiplexer:
// mode encodings, transfer-counter width and a saturating increment helper.
package arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int CNT_W = 16;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first requesting
// channel found searching upward from last_grant+1, wrapping modulo NUM_IN.
// Fixed-select arbitration reuses it by presenting a single-bit request.
module rr_pick #(
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic              grant_valid,
  output logic [SEL_W-1:0]  grant_idx
);

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = NUM_IN; off >= 1; off--) begin
      idx = SEL_W'((int'(last_grant) + off) % NUM_IN);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input arbitrating multiplexer with a single registered output slot.
// mode selects fixed channel select or round-robin arbitration; the slot
// reloads in the same cycle it drains, giving one word per cycle.
// Optional feature: define RR_ARB_MUX_CNT_EN to add the saturating
// output-transfer counter port xfer_cnt.
module rr_arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef RR_ARB_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0]        xfer_cnt
`endif
);

  logic [SEL_W-1:0]  last_grant;
  logic [NUM_IN-1:0] req_fixed;
  logic [NUM_IN-1:0] req;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic              loadable;
  logic              in_xfer;

  // Build the request vector: all valids in round-robin, only sel in fixed mode.
  always_comb begin
    req_fixed = '0;
    if (int'(sel) < NUM_IN) begin
      req_fixed[sel] = in_valid[sel];
    end
    req = (mode == MODE_FIXED) ? req_fixed : in_valid;
  end

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Accept only into an empty slot or one draining this cycle; never in reset.
  always_comb begin
    loadable = !out_valid || out_ready;
    in_xfer  = rst_n && loadable && grant_valid;
    in_ready = in_xfer ? (NUM_IN'(1) << grant_idx) : '0;
  end

  // Output slot and arbitration history; a stalled slot holds its contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= SEL_W'(NUM_IN - 1);
    end else if (loadable) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data   <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_chan   <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

`ifdef RR_ARB_MUX_CNT_EN
  // Count output transfers, saturating at the maximum value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= sat_inc(xfer_cnt);
    end
  end
`endif

endmodule
